flash_spi_master: RTL and testbench

FLASH_SPI_MASTER -- requirements
Module: flash_spi_master

---
 rtl/flash_spi_pkg.sv | 14 +
 rtl/flash_spi_sck_gen.sv | 50 +++++
 rtl/flash_spi_master.sv | 177 +++++++++++++++++
 tb/tb_flash_spi_master.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/flash_spi_pkg.sv
// Shared definitions for the flash SPI master: FSM state encoding and the
// default SCK divider width.
package flash_spi_pkg;

    localparam int unsigned DIV_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_TRAIL = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/flash_spi_sck_gen.sv
// SCK half-period counter and phase generator: loads the divider on a start,
// then ticks every (D+1) cycles while running and toggles the SCK phase.
module flash_spi_sck_gen
    import flash_spi_pkg::*;
#(
    parameter int unsigned pDivClk = DIV_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               run,
    input  logic [pDivClk-1:0] div,
    output logic               tick,
    output logic               phase
);

    localparam logic [pDivClk-1:0] CNT_ZERO = {pDivClk{1'b0}};
    localparam logic [pDivClk-1:0] CNT_ONE  = {{(pDivClk-1){1'b0}}, 1'b1};

    logic [pDivClk-1:0] cnt_r;
    logic [pDivClk-1:0] div_r;
    logic               phase_r;

    assign tick  = run && (cnt_r == CNT_ZERO);
    assign phase = phase_r;

    // Half-period countdown; reloads the latched divider at zero so D=all-ones never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            div_r   <= CNT_ZERO;
            phase_r <= 1'b0;
        end else if (load) begin
            cnt_r   <= div;
            div_r   <= div;
            phase_r <= 1'b0;
        end else if (run) begin
            if (cnt_r == CNT_ZERO) begin
                cnt_r   <= div_r;
                phase_r <= ~phase_r;
            end else begin
                cnt_r   <= cnt_r - CNT_ONE;
            end
        end else begin
            cnt_r   <= cnt_r;
            phase_r <= phase_r;
        end
    end

endmodule

// File: rtl/flash_spi_master.sv
// SPI mode-0 byte master for a serial flash. Optional two-flop MISO
// synchronizer enabled by defining FLASH_SPI_MISO_SYNC_EN (then D must be >= 2).
module flash_spi_master
    import flash_spi_pkg::*;
#(
    parameter int unsigned pDivClk = DIV_W_DEFAULT
) (
    input  logic               iSCLK,
    input  logic               iSRST,
    input  logic               iSpiEn,
    input  logic [pDivClk-1:0] iSpiDiv,
    input  logic [7:0]         iWd,
    input  logic               iCsOutCtrl,
    input  logic               iSpiIoHiz,
    input  logic               iSpiMiso,
    output logic [7:0]         oRd,
    output logic               oSpiIntr,
    output logic               oSpiSck,
    output logic               oSpiMosi,
    output logic               oSpiCs,
    output logic               oSpiOe
);

    spi_state_e state_r, state_nxt;
    logic [7:0] rd_r, rd_nxt;
    logic [7:0] rx_r, rx_nxt;
    logic [7:0] tx_r, tx_nxt;
    logic [2:0] bit_cnt_r, bit_cnt_nxt;
    logic       sck_r, sck_nxt;
    logic       mosi_r, mosi_nxt;
    logic       intr_r, intr_nxt;
    logic       en_prev_r, en_prev_nxt;
    logic       cs_r;
    logic       oe_r;
    logic       load_s;
    logic       run_s;
    logic       tick_s;
    logic       phase_s;
    logic       miso_s;

`ifdef FLASH_SPI_MISO_SYNC_EN
    logic [1:0] miso_sync_r;

    // Two-flop synchronizer for the asynchronous flash data line
    always_ff @(posedge iSCLK or posedge iSRST) begin
        if (iSRST) begin
            miso_sync_r <= 2'b00;
        end else begin
            miso_sync_r <= {miso_sync_r[0], iSpiMiso};
        end
    end

    assign miso_s = miso_sync_r[1];
`else
    assign miso_s = iSpiMiso;
`endif

    flash_spi_sck_gen #(
        .pDivClk (pDivClk)
    ) u_sck_gen (
        .clk   (iSCLK),
        .rst   (iSRST),
        .load  (load_s),
        .run   (run_s),
        .div   (iSpiDiv),
        .tick  (tick_s),
        .phase (phase_s)
    );

    // Next-state and next-output logic for the byte transfer FSM
    always_comb begin
        state_nxt   = state_r;
        rd_nxt      = rd_r;
        rx_nxt      = rx_r;
        tx_nxt      = tx_r;
        bit_cnt_nxt = bit_cnt_r;
        sck_nxt     = sck_r;
        mosi_nxt    = mosi_r;
        intr_nxt    = 1'b0;
        en_prev_nxt = iSpiEn;
        load_s      = 1'b0;
        run_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sck_nxt = 1'b0;
                // While the pins belong to GPIO the edge history is frozen, so a
                // level already high starts once the pins return, but an aborted
                // transfer with iSpiEn still held does not retrigger.
                if (iSpiIoHiz) begin
                    en_prev_nxt = iSpiEn;
                end else begin
                    en_prev_nxt = en_prev_r;
                end
                if (iSpiEn && !en_prev_r && iSpiIoHiz) begin
                    load_s      = 1'b1;
                    state_nxt   = ST_LEAD;
                    tx_nxt      = iWd;
                    mosi_nxt    = iWd[7];
                    rx_nxt      = 8'h00;
                    bit_cnt_nxt = 3'd0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LEAD, ST_TRAIL: begin
                run_s = 1'b1;
                if (!iSpiIoHiz) begin
                    state_nxt = ST_IDLE;
                    sck_nxt   = 1'b0;
                end else if (tick_s) begin
                    if (!phase_s) begin
                        state_nxt = ST_TRAIL;
                        sck_nxt   = 1'b1;
                        rx_nxt    = {rx_r[6:0], miso_s};
                    end else if (bit_cnt_r == 3'd7) begin
                        state_nxt = ST_DONE;
                        sck_nxt   = 1'b0;
                        rd_nxt    = rx_r;
                        intr_nxt  = 1'b1;
                    end else begin
                        state_nxt   = ST_LEAD;
                        sck_nxt     = 1'b0;
                        mosi_nxt    = tx_r[6];
                        tx_nxt      = {tx_r[6:0], 1'b0};
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                sck_nxt   = 1'b0;
            end
        endcase
    end

    // FSM state and all registered outputs
    always_ff @(posedge iSCLK or posedge iSRST) begin
        if (iSRST) begin
            state_r   <= ST_IDLE;
            rd_r      <= 8'h00;
            rx_r      <= 8'h00;
            tx_r      <= 8'h00;
            bit_cnt_r <= 3'd0;
            sck_r     <= 1'b0;
            mosi_r    <= 1'b0;
            intr_r    <= 1'b0;
            en_prev_r <= 1'b0;
            cs_r      <= 1'b1;
            oe_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            rd_r      <= rd_nxt;
            rx_r      <= rx_nxt;
            tx_r      <= tx_nxt;
            bit_cnt_r <= bit_cnt_nxt;
            sck_r     <= sck_nxt;
            mosi_r    <= mosi_nxt;
            intr_r    <= intr_nxt;
            en_prev_r <= en_prev_nxt;
            cs_r      <= iCsOutCtrl;
            oe_r      <= iSpiIoHiz;
        end
    end

    assign oRd      = rd_r;
    assign oSpiIntr = intr_r;
    assign oSpiSck  = sck_r;
    assign oSpiMosi = mosi_r;
    assign oSpiCs   = cs_r;
    assign oSpiOe   = oe_r;

endmodule

// File: tb/tb_flash_spi_master.sv
// Self-checking bench for flash_spi_master: directed scenarios plus randomized
// transfers compared against a cycle-position model of the SPI waveform.
module tb_flash_spi_master;

    localparam int DW = 16;

    logic          iSCLK = 1'b0;
    logic          iSRST;
    logic          iSpiEn;
    logic [DW-1:0] iSpiDiv;
    logic [7:0]    iWd;
    logic          iCsOutCtrl;
    logic          iSpiIoHiz;
    logic          iSpiMiso;
    logic [7:0]    oRd;
    logic          oSpiIntr;
    logic          oSpiSck;
    logic          oSpiMosi;
    logic          oSpiCs;
    logic          oSpiOe;

    logic          loopback;
    logic          miso_drv;
    logic [7:0]    last_rd;
    int            n_checks = 0;
    int            n_errors = 0;

    flash_spi_master #(.pDivClk(DW)) dut (
        .iSCLK      (iSCLK),
        .iSRST      (iSRST),
        .iSpiEn     (iSpiEn),
        .iSpiDiv    (iSpiDiv),
        .iWd        (iWd),
        .iCsOutCtrl (iCsOutCtrl),
        .iSpiIoHiz  (iSpiIoHiz),
        .iSpiMiso   (iSpiMiso),
        .oRd        (oRd),
        .oSpiIntr   (oSpiIntr),
        .oSpiSck    (oSpiSck),
        .oSpiMosi   (oSpiMosi),
        .oSpiCs     (oSpiCs),
        .oSpiOe     (oSpiOe)
    );

    always #5 iSCLK = ~iSCLK;

    assign iSpiMiso = loopback ? oSpiMosi : miso_drv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: chip select and pad enable must be the values presented before the edge
    task automatic tick();
        logic cs_q;
        logic oe_q;
        cs_q = iCsOutCtrl;
        oe_q = iSpiIoHiz;
        @(posedge iSCLK);
        #1;
        if (!iSRST) begin
            chk("cs_follow", 32'(oSpiCs), 32'(cs_q));
            chk("oe_follow", 32'(oSpiOe), 32'(oe_q));
        end
    endtask

    // mode 0: MISO looped from MOSI, 1: MISO tied high, 2: random MISO
    task automatic run_xfer(input int d, input logic [7:0] w, input int mode, input bit junk);
        int         n;
        int         p;
        int         bi;
        logic [7:0] exp_rx;
        n        = 16 * (d + 1);
        exp_rx   = 8'h00;
        loopback = (mode == 0);
        miso_drv = (mode == 1);
        tick();
        chk("start_sck", 32'(oSpiSck), 32'd0);
        chk("start_mosi", 32'(oSpiMosi), 32'(w[7]));
        chk("start_intr", 32'(oSpiIntr), 32'd0);
        for (int k = 1; k <= n + 1; k++) begin
            if (mode == 2) miso_drv = 1'($urandom_range(0, 1));
            if (junk) begin
                iWd        = 8'($urandom);
                iSpiDiv    = DW'($urandom_range(0, 7));
                iSpiEn     = (k >= n - 2) ? 1'b1 : 1'($urandom_range(0, 1));
                iCsOutCtrl = 1'($urandom_range(0, 1));
            end
            tick();
            p = k / (d + 1);
            if ((k % (d + 1) == 0) && (p % 2 == 1) && (p < 16)) begin
                bi = 7 - (p - 1) / 2;
                exp_rx[bi] = (mode == 0) ? w[bi] : miso_drv;
            end
            chk("sck", 32'(oSpiSck), 32'((p < 16) && (p % 2 == 1)));
            chk("mosi", 32'(oSpiMosi), 32'((p < 16) ? w[7 - p / 2] : w[0]));
            chk("intr", 32'(oSpiIntr), 32'(k == n));
            if (k >= n) chk("rd", 32'(oRd), 32'(exp_rx));
        end
        last_rd = exp_rx;
    endtask

    initial begin
        int pulses;
        iSRST = 1'b0; iSpiEn = 1'b0; iSpiDiv = '0; iWd = 8'h00;
        iCsOutCtrl = 1'b1; iSpiIoHiz = 1'b0; miso_drv = 1'b0; loopback = 1'b1;
        last_rd = 8'h00;
        #1 iSRST = 1'b1;
        #1;
        chk("rst_rd", 32'(oRd), 32'd0);
        chk("rst_intr", 32'(oSpiIntr), 32'd0);
        chk("rst_sck", 32'(oSpiSck), 32'd0);
        chk("rst_mosi", 32'(oSpiMosi), 32'd0);
        chk("rst_cs", 32'(oSpiCs), 32'd1);
        chk("rst_oe", 32'(oSpiOe), 32'd0);

        // iSpiEn already high at release: first edge starts; D=0 loopback 0xA5
        iSpiEn = 1'b1; iSpiIoHiz = 1'b1; iWd = 8'hA5; iSpiDiv = 16'd0;
        tick(); tick();
        iSRST = 1'b0;
        run_xfer(0, 8'hA5, 0, 1'b0);
        iSpiEn = 1'b0; tick();

        // D=3, MISO tied high
        iSpiEn = 1'b1; iSpiDiv = 16'd3; iWd = 8'h3C;
        run_xfer(3, 8'h3C, 1, 1'b0);
        iSpiEn = 1'b0; tick();
        chk("ones_rd", 32'(oRd), 32'h0000_00FF);

        // Held-high enable: one transfer only across 200 cycles
        iSpiEn = 1'b1; iSpiDiv = 16'd0; iWd = 8'h96;
        run_xfer(0, 8'h96, 0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 181; i++) begin
            tick();
            if (oSpiIntr) pulses++;
            chk("held_sck", 32'(oSpiSck), 32'd0);
        end
        chk("held_pulses", 32'(pulses), 32'd0);
        iSpiEn = 1'b0; tick();
        iSpiEn = 1'b1; iWd = 8'h4E;
        run_xfer(0, 8'h4E, 0, 1'b0);
        iSpiEn = 1'b0; tick();

        // Chip select follows with one cycle latency, independent of the FSM
        iCsOutCtrl = 1'b0;
        chk("cs_lat0", 32'(oSpiCs), 32'd1);
        tick();
        iSpiEn = 1'b1; iSpiDiv = 16'd1; iWd = 8'hC3;
        run_xfer(1, 8'hC3, 2, 1'b0);
        iCsOutCtrl = 1'b1;
        chk("cs_lat1", 32'(oSpiCs), 32'd0);
        iSpiEn = 1'b0; tick();

        // Randomized transfers with input churn during the byte
        for (int t = 0; t < 5; t++) begin
            int         d;
            logic [7:0] w;
            d = int'($urandom_range(0, 4));
            w = 8'($urandom);
            iSpiEn = 1'b1; iSpiDiv = DW'(d); iWd = w;
            run_xfer(d, w, 2, 1'b1);
            iSpiEn = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("rd_hold", 32'(oRd), 32'(last_rd));
                chk("idle_intr", 32'(oSpiIntr), 32'd0);
            end
        end

        // Pins released to GPIO after the third SCK rise
        iCsOutCtrl = 1'b1;
        iSpiEn = 1'b1; iSpiDiv = 16'd1; iWd = 8'h5A; loopback = 1'b0; miso_drv = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) tick();
        chk("abort_pre_sck", 32'(oSpiSck), 32'd1);
        iSpiIoHiz = 1'b0;
        tick();
        chk("abort_sck", 32'(oSpiSck), 32'd0);
        chk("abort_oe", 32'(oSpiOe), 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (oSpiIntr) pulses++;
            chk("abort_sck_idle", 32'(oSpiSck), 32'd0);
            chk("abort_rd", 32'(oRd), 32'(last_rd));
        end
        chk("abort_pulses", 32'(pulses), 32'd0);
        iSpiEn = 1'b0; tick();
        iSpiIoHiz = 1'b1; tick();

        // Asynchronous reset between clock edges, mid-byte
        iSpiEn = 1'b1; iSpiDiv = 16'd2; iWd = 8'hFF; miso_drv = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) tick();
        chk("pre_rst_mosi", 32'(oSpiMosi), 32'd1);
        #3 iSRST = 1'b1;
        #1;
        chk("arst_rd", 32'(oRd), 32'd0);
        chk("arst_intr", 32'(oSpiIntr), 32'd0);
        chk("arst_sck", 32'(oSpiSck), 32'd0);
        chk("arst_mosi", 32'(oSpiMosi), 32'd0);
        chk("arst_cs", 32'(oSpiCs), 32'd1);
        chk("arst_oe", 32'(oSpiOe), 32'd0);
        iSpiEn = 1'b0;
        tick();
        iSRST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (oSpiIntr) pulses++;
            chk("post_rst_sck", 32'(oSpiSck), 32'd0);
            chk("post_rst_rd", 32'(oRd), 32'd0);
        end
        chk("post_rst_pulses", 32'(pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
